// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder datapath.
package adder_pkg;

    // Controller states of the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Supported operand widths.
    localparam int unsigned NBITS_MIN = 1;
    localparam int unsigned NBITS_MAX = 16;

    // Width of the bit counter, wide enough to hold 0..nbits.
    function automatic int unsigned cnt_width(input int unsigned nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/full_adder_1b.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_half;

    assign w_half = a ^ b;
    assign sum    = w_half ^ cin;
    assign cout   = (a & b) | (cin & w_half);

endmodule

// File: rtl/serial_adder_4b.sv
// Bit-serial adder: accepts two NBITS operands plus carry-in over a val/rdy
// stream, adds one bit per clock through a single full adder, and returns
// {cout, sum} over a val/rdy stream. Sequence: IDLE -> CALC (NBITS edges)
// -> DONE (held until the consumer takes the result) -> IDLE.
module serial_adder_4b
    import adder_pkg::*;
#(
    parameter int unsigned NBITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    input  logic             cin,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [NBITS-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = cnt_width(NBITS);

    // Controller and datapath state.
    state_t             r_state;
    logic [NBITS-1:0]   r_op_a;
    logic [NBITS-1:0]   r_op_b;
    logic [NBITS-1:0]   r_sum;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    // Combinational helpers.
    state_t             w_next_state;
    logic               w_accept;
    logic               w_last_bit;
    logic               w_fa_sum;
    logic               w_fa_cout;

    // The full adder always looks at the current LSBs and the running carry;
    // its result is only committed while in CALC.
    full_adder_1b u_fa (
        .a    (r_op_a[0]),
        .b    (r_op_b[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    assign w_accept   = istream_val & istream_rdy;
    assign w_last_bit = (r_cnt == CNT_W'(NBITS - 1));

    // The result is read straight from the accumulator; outside DONE it shows
    // the partially shifted value.
    assign sum  = r_sum;
    assign cout = r_carry;

    // Next-state and handshake outputs from the current state.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        istream_rdy  = 1'b0;
        ostream_val  = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Held low while reset is asserted so nothing is offered
                // before the block is actually out of reset.
                istream_rdy = rst_n;
                if (istream_val && rst_n) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                if (w_last_bit) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // No bypass: a new operand pair is only taken from IDLE.
                ostream_val = 1'b1;
                if (ostream_rdy) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register plus the shift/accumulate datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge value of the others (e.g. r_carry feeds the adder
            // whose output also updates r_carry).
            r_state <= w_next_state;
            unique case (r_state)
                IDLE: begin
                    // Operands and carry-in are captured only on the accepting
                    // edge; later input changes are ignored.
                    if (w_accept) begin
                        r_op_a  <= in0;
                        r_op_b  <= in1;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                CALC: begin
                    // LSB-first: the new sum bit enters at the MSB so after
                    // NBITS shifts bit 0 of the sum lands at position 0.
                    r_sum   <= (r_sum >> 1) | (NBITS'(w_fa_sum) << (NBITS - 1));
                    r_carry <= w_fa_cout;
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                DONE: begin
                    // Result held stable until the consumer accepts it.
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_4b.sv
// Self-checking bench for serial_adder_4b (NBITS = 4).
module tb_serial_adder_4b;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       istream_val = 1'b0;
    logic       istream_rdy;
    logic [3:0] in0 = 4'd0;
    logic [3:0] in1 = 4'd0;
    logic       cin = 1'b0;
    logic       ostream_val;
    logic       ostream_rdy;
    logic [3:0] sum;
    logic       cout;

    logic       rdy_man = 1'b1;
    logic       rdy_rand = 1'b1;
    logic       rand_mode = 1'b0;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [4:0] sb[$];
    time        t_accept;

    assign ostream_rdy = rand_mode ? rdy_rand : rdy_man;

    serial_adder_4b #(.NBITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .in0         (in0),
        .in1         (in1),
        .cin         (cin),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .sum         (sum),
        .cout        (cout)
    );

    always #5 clk = ~clk;

    // Random consumer stalls, changed just after each rising edge.
    always @(posedge clk) begin
        #1 rdy_rand = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every output handshake pops the oldest expected result.
    always @(negedge clk) begin
        logic [4:0] exp;
        if (rst_n && ostream_val && ostream_rdy) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%0h with no result pending at t=%0t",
                         {cout, sum}, $time);
            end else begin
                exp = sb.pop_front();
                check("result", 32'({cout, sum}), 32'(exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair; returns 1 time unit after the accepting edge.
    // Must be called 1 time unit after a rising edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [4:0] exp, input bit push);
        int n = 0;
        in0 = a;
        in1 = b;
        cin = c;
        istream_val = 1'b1;
        @(negedge clk);
        while (!istream_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!istream_rdy) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: istream_rdy never rose within %0d cycles", n);
        end
        @(posedge clk);
        t_accept = $time;
        #1 istream_val = 1'b0;
        if (push) sb.push_back(exp);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        time  t_prev;
        int   k;

        vecs[0] = '{a: 4'd15, b: 4'd1,  c: 1'b0, exp_sum: 4'd0,  exp_cout: 1'b1};
        vecs[1] = '{a: 4'd15, b: 4'd15, c: 1'b1, exp_sum: 4'd15, exp_cout: 1'b1};
        vecs[2] = '{a: 4'd0,  b: 4'd0,  c: 1'b0, exp_sum: 4'd0,  exp_cout: 1'b0};
        vecs[3] = '{a: 4'd0,  b: 4'd0,  c: 1'b1, exp_sum: 4'd1,  exp_cout: 1'b0};
        vecs[4] = '{a: 4'd10, b: 4'd5,  c: 1'b1, exp_sum: 4'd0,  exp_cout: 1'b1};
        vecs[5] = '{a: 4'd12, b: 4'd3,  c: 1'b0, exp_sum: 4'd15, exp_cout: 1'b0};

        // Reset values while rst_n is low.
        #12;
        check("rst_istream_rdy", 32'(istream_rdy), 32'd0);
        check("rst_ostream_val", 32'(ostream_val), 32'd0);
        check("rst_sum",         32'(sum),         32'd0);
        check("rst_cout",        32'(cout),        32'd0);
        #5 rst_n = 1'b1;
        tick();
        check("idle_istream_rdy", 32'(istream_rdy), 32'd1);

        // 3 + 5: accept edge is the first of five edges, so ostream_val is
        // seen four edges after the accepting one.
        send(4'd3, 4'd5, 1'b0, 5'd8, 1'b1);
        k = 0;
        while (!ostream_val && k < 20) begin
            tick();
            k++;
        end
        check("latency_edges", 32'(k), 32'd4);
        check("done_istream_rdy", 32'(istream_rdy), 32'd0);
        tick();
        check("post_done_istream_rdy", 32'(istream_rdy), 32'd1);
        check("post_done_ostream_val", 32'(ostream_val), 32'd0);
        drain();

        // Table vectors back to back; accepts must be exactly 6 cycles apart.
        t_prev = 0;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].c, {vecs[i].exp_cout, vecs[i].exp_sum}, 1'b1);
            if (i > 0) check("accept_spacing", 32'(t_accept - t_prev), 32'd60);
            t_prev = t_accept;
        end
        drain();

        // Backpressure: result must hold while stray istream_val pulses arrive.
        rdy_man = 1'b0;
        send(4'd6, 4'd9, 1'b0, 5'd15, 1'b1);
        k = 0;
        while (!ostream_val && k < 20) begin
            tick();
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            istream_val = (i % 3 == 0);
            in0 = 4'(i);
            in1 = 4'hF;
            @(negedge clk);
            check("stall_hold", 32'({ostream_val, cout, sum}), 32'({1'b1, 1'b0, 4'd15}));
            check("stall_no_rdy", 32'(istream_rdy), 32'd0);
            tick();
        end
        istream_val = 1'b0;
        rdy_man = 1'b1;
        tick();
        check("release_ostream_val", 32'(ostream_val), 32'd0);
        check("release_istream_rdy", 32'(istream_rdy), 32'd1);
        drain();

        // Operand changes after the accept must not affect the result.
        send(4'd7, 4'd2, 1'b0, 5'd9, 1'b1);
        in0 = 4'hF;
        in1 = 4'hF;
        cin = 1'b1;
        drain();
        cin = 1'b0;

        // Asynchronous reset after two CALC edges discards the operation.
        send(4'd10, 4'd10, 1'b0, 5'd0, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_istream_rdy", 32'(istream_rdy), 32'd0);
        check("arst_ostream_val", 32'(ostream_val), 32'd0);
        check("arst_sum",         32'(sum),         32'd0);
        check("arst_cout",        32'(cout),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("arst_no_result", 32'(ostream_val), 32'd0);
        end
        check("arst_idle_rdy", 32'(istream_rdy), 32'd1);
        send(4'd1, 4'd1, 1'b0, 5'd2, 1'b1);
        drain();

        // All 512 operand combinations with random consumer stalls.
        rand_mode = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    send(4'(a), 4'(b), 1'(c), 5'(a + b + c), 1'b1);
                end
            end
        end
        drain();
        rand_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
